// File: rtl/spi_sevenseg_mux.sv
// SPI-programmed multiplexed seven-segment driver: 16-bit command frames from an
// asynchronous SPI master set digit contents, hex-decode mask, brightness and enable.
module spi_sevenseg_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_ok,
    output logic                  frame_err
);

    localparam int SUB_LEN = REFRESH_DIV / 16;
    localparam int SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
    localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [1:0]            r_sclk_s, r_cs_s, r_mosi_s;
    logic                  r_sclk_d, r_cs_d;
    logic [2:0]            r_vld;
    logic [15:0]           r_shift;
    logic [4:0]            r_bit_cnt;
    logic                  r_in_frame;
    logic                  r_frame_ok, r_frame_err;
    logic [7:0]            r_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_dec_mask;
    logic [3:0]            r_bright;
    logic                  r_enable;
    logic [SUB_W-1:0]      r_sub_cnt;
    logic [3:0]            r_subph;
    logic [SLOT_W-1:0]     r_slot;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_digit_en;

    logic                  w_sclk_rise, w_cs_fall, w_cs_rise;
    logic [3:0]            w_cmd, w_addr;
    logic [7:0]            w_data;
    logic [7:0]            w_sel;
    logic                  w_dec;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                  w_active;
    logic [6:0]            w_font;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_s <= 2'b00;
            r_cs_s   <= 2'b11;
            r_mosi_s <= 2'b00;
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b1;
            r_vld    <= 3'b000;
        end else begin
            r_sclk_s <= {r_sclk_s[0], sclk};
            r_cs_s   <= {r_cs_s[0], cs_n};
            r_mosi_s <= {r_mosi_s[0], mosi};
            r_sclk_d <= r_sclk_s[1];
            r_cs_d   <= r_cs_s[1];
            r_vld    <= {r_vld[1:0], 1'b1};
        end
    end

    assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
    assign w_cs_fall   = ~r_cs_s[1] & r_cs_d;
    assign w_cs_rise   = r_cs_s[1] & ~r_cs_d;
    assign w_cmd       = r_shift[15:12];
    assign w_addr      = r_shift[11:8];
    assign w_data      = r_shift[7:0];

    // r_vld masks the reset-forced cs_n=1 so a frame already in progress at reset is never picked up
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_in_frame  <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_dec_mask  <= '0;
            r_bright    <= '0;
            r_enable    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_cs_fall && r_vld[2]) begin
                r_in_frame <= 1'b1;
                r_bit_cnt  <= '0;
            end else if (r_in_frame && w_cs_rise) begin
                r_in_frame <= 1'b0;
                if (r_bit_cnt == 5'd16) begin
                    r_frame_ok <= 1'b1;
                    case (w_cmd)
                        4'h1: for (int i = 0; i < NUM_DIGITS; i++)
                                  if (w_addr == 4'(i)) r_digit[i] <= w_data;
                        4'h2: r_dec_mask <= w_data[NUM_DIGITS-1:0];
                        4'h3: r_bright   <= w_data[3:0];
                        4'h4: r_enable   <= w_data[0];
                        4'h5: for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
                        default: ;
                    endcase
                end else begin
                    r_frame_err <= 1'b1;
                end
            end else if (r_in_frame && w_sclk_rise && !r_cs_s[1]) begin
                r_shift <= {r_shift[14:0], r_mosi_s[1]};
                if (r_bit_cnt != 5'd17) r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sub_cnt <= SUB_W'(SUB_LEN - 1);
            r_subph   <= '0;
            r_slot    <= '0;
        end else if (r_sub_cnt == '0) begin
            r_sub_cnt <= SUB_W'(SUB_LEN - 1);
            r_subph   <= r_subph + 4'd1;
            if (r_subph == 4'd15)
                r_slot <= (r_slot == SLOT_W'(NUM_DIGITS - 1)) ? '0 : r_slot + SLOT_W'(1);
        end else begin
            r_sub_cnt <= r_sub_cnt - SUB_W'(1);
        end
    end

    always_comb begin
        w_sel    = '0;
        w_dec    = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_sel       = r_digit[i];
                w_dec       = r_dec_mask[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_active = r_enable && (r_subph <= r_bright);
    assign w_font   = w_dec ? hex_font(w_sel[3:0]) : w_sel[6:0];

    always_ff @(posedge clk) begin
        if (!rst_n || !w_active) begin
            r_seg      <= '0;
            r_dp       <= 1'b0;
            r_digit_en <= '0;
        end else begin
            r_seg      <= w_font;
            r_dp       <= w_sel[7];
            r_digit_en <= w_onehot;
        end
    end

    assign seg       = r_seg;
    assign dp        = r_dp;
    assign digit_en  = r_digit_en;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_sevenseg_mux.sv
// Directed bench for spi_sevenseg_mux: SPI frames bit-banged from the bench, display
// scanned over one full refresh period per check with hand-computed expectations.
module tb_spi_sevenseg_mux;

    localparam int ND = 4;
    localparam int RD = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          cs_n = 1'b1;
    logic          mosi = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] digit_en;
    logic          frame_ok;
    logic          frame_err;

    int n_chk = 0;
    int n_pass = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int ok_base, err_base;

    spi_sevenseg_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .seg(seg), .dp(dp), .digit_en(digit_en),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] v, input int nb);
        cs_n = 1'b0;
        clks(4);
        for (int i = nb - 1; i >= 0; i--) begin
            mosi = v[i];
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        clks(4);
        cs_n = 1'b1;
        mosi = 1'b0;
        clks(10);
    endtask

    task automatic spi(input logic [15:0] w);
        spi_bits({16'h0, w}, 16);
    endtask

    // Observe one full scan period: active cycles of digit d, its seg/dp, and any
    // inconsistency (changing value, outputs while blank, non-one-hot select).
    task automatic chk_digit(input string tag, input int d, input int exp_act,
                             input logic [6:0] exp_seg, input logic exp_dp);
        int         act = 0;
        int         bad = 0;
        logic [6:0] s = '0;
        logic       p = 1'b0;
        logic [ND-1:0] tgt;
        tgt = ND'(1) << d;
        repeat (4 * RD) begin
            @(negedge clk);
            if (digit_en == tgt) begin
                if (act > 0 && (seg !== s || dp !== p)) bad++;
                s = seg;
                p = dp;
                act++;
            end else if (digit_en == '0) begin
                if (seg != '0 || dp != 1'b0) bad++;
            end else if ($countones(digit_en) != 1) begin
                bad++;
            end
        end
        chk({tag, ".active"}, act, exp_act);
        chk({tag, ".seg"}, {25'h0, s}, {25'h0, exp_seg});
        chk({tag, ".dp"}, {31'h0, p}, {31'h0, exp_dp});
        chk({tag, ".glitch"}, bad, 0);
    endtask

    initial begin
        clks(5);
        @(negedge clk);
        chk("reset.outputs", {seg, dp, digit_en, frame_ok, frame_err}, '0);
        @(posedge clk);
        rst_n = 1'b1;
        clks(10);
        chk_digit("reset.disabled", 0, 0, 7'h00, 1'b0);

        spi(16'h4001);
        spi(16'h30FF);
        spi(16'h1205);
        chk("basic.ok_cnt", ok_cnt, 3);
        chk("basic.err_cnt", err_cnt, 0);
        chk_digit("basic.d2", 2, RD, 7'h05, 1'b0);

        spi(16'h200F);
        spi(16'h1088);
        chk_digit("dec.d0", 0, RD, 7'h7F, 1'b1);
        chk_digit("dec.d1", 1, RD, 7'h3F, 1'b0);
        chk_digit("dec.d2", 2, RD, 7'h6D, 1'b0);

        spi(16'h3003);
        chk_digit("bright3.d0", 0, 4 * RD / 16, 7'h7F, 1'b1);

        ok_base  = ok_cnt;
        err_base = err_cnt;
        spi_bits(32'h0000_1211, 15);
        spi_bits(32'h0001_1033, 17);
        chk("badlen.err", err_cnt - err_base, 2);
        chk("badlen.ok", ok_cnt - ok_base, 0);
        chk_digit("badlen.d0", 0, 4 * RD / 16, 7'h7F, 1'b1);
        spi(16'h1905);
        chk("addr9.ok", ok_cnt - ok_base, 1);
        chk("addr9.err", err_cnt - err_base, 2);
        chk_digit("addr9.d1", 1, 4 * RD / 16, 7'h3F, 1'b0);
        spi(16'h7123);
        chk("badcmd.ok", ok_cnt - ok_base, 2);
        chk_digit("badcmd.d2", 2, 4 * RD / 16, 7'h6D, 1'b0);

        spi(16'h2000);
        spi(16'h5000);
        chk_digit("clear.d0", 0, 4 * RD / 16, 7'h00, 1'b0);
        chk_digit("clear.d2", 2, 4 * RD / 16, 7'h00, 1'b0);
        spi(16'h4000);
        chk_digit("off.d0", 0, 0, 7'h00, 1'b0);
        chk_digit("off.d3", 3, 0, 7'h00, 1'b0);

        spi(16'h4001);
        spi(16'h1342);
        ok_base  = ok_cnt;
        err_base = err_cnt;
        cs_n = 1'b0;
        clks(4);
        for (int i = 7; i >= 0; i--) begin
            mosi = i[0];
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        clks(3);
        @(negedge clk);
        chk("midrst.outputs", {seg, dp, digit_en, frame_ok, frame_err}, '0);
        @(posedge clk);
        rst_n = 1'b1;
        clks(10);
        cs_n = 1'b1;
        mosi = 1'b0;
        clks(10);
        chk("midrst.ok", ok_cnt - ok_base, 0);
        chk("midrst.err", err_cnt - err_base, 0);
        chk_digit("midrst.d3", 3, 0, 7'h00, 1'b0);
        spi(16'h4001);
        chk("midrst.next_ok", ok_cnt - ok_base, 1);
        chk_digit("midrst.d1", 1, RD / 16, 7'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
